alu_seq_dec: RTL and testbench
==============================

# alu_seq_dec

Parametrised, sequenced successor to the combinational ALU decoder. Accepts one decode request (opcode, ALU-op class, shift amount) per handshake and emits a registered stream of ALU control beats to the datapath. Multi-bit shifts are broken into single-bit shift micro-ops, one beat per bit, so the 1-bit-shift ALU can run variable shifts. Sits between the main control decoder and the ALU/register-writeback sequencer.

## Interface
- OPW, 4, opcode width; must be ≥3; only op[2:0] is decoded, op[OPW-1:3] ignored
- CNTW, 2, shift-amount width; maximum shift is 2^CNTW-1
- CTLW, 4, control width; must be ≥4; bits above [3:0] always 0
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  request accepted when in_valid && in_ready
- op  input  OPW  function field
- aluop  input  2  ALU-op class from main decoder
- shamt  input  CNTW  shift amount, used only for shift functions
- out_valid  output  1  alucontrol/last valid
- out_ready  input  1  consumer takes beat when out_valid && out_ready
- alucontrol  output  CTLW  registered ALU control code
- last  output  1  final beat of the current request
- busy  output  1  beats remaining after the one presented (state SHIFT)

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOT 0101, SLL1 0110, SRL1 0111, PASSB 1000, PASSA 1001.
- Class decode: aluop 00 → ADD; 01 → SUB; 11 → PASSB; 10 → op[2:0]: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SLL, 111 SRL.
- Non-shift requests: exactly one beat, last=1.
- Shift (aluop 10, op[2:1]=11), shamt=N: N≥1 → N beats of SLL1/SRL1, last=1 only on beat N; N=0 → one PASSA beat, last=1.
- FSM states: IDLE (out_valid=0), HOLD (presenting last beat), SHIFT (presenting a non-final beat, remaining counter rem ≥1).
  - IDLE/HOLD + accept: → SHIFT with rem=N-1 if shift and N≥2; else → HOLD.
  - HOLD + out_ready, no accept: → IDLE.
  - SHIFT + out_ready: rem-1; when rem reaches 0 the beat now presented has last=1 → HOLD.
  - No out_ready: all outputs and rem hold.
- in_ready = !reset && state≠SHIFT && (!out_valid || out_ready); combinational.
- Code and shift direction captured at accept; later input changes do not affect an ongoing sequence.
- rem is CNTW bits, never wraps: decremented only when ≥1.

## Timing
- Reset values: out_valid=0, alucontrol=0, last=0, busy=0, state IDLE, rem=0; in_ready=0 while reset is high, 1 the cycle after.
- Latency: request accepted at edge t → first beat valid after edge t (visible cycle t+1).
- Throughput: single-beat requests 1 per cycle with out_ready held high; shift of N occupies N cycles, next request accepted in the cycle the final beat is taken.
- Simultaneous final-beat handoff and new accept: new beat replaces old beat in same edge, no bubble.
- Reset mid-sequence: remaining beats dropped, out_valid=0 the next cycle; no partial resume.
- busy=1 exactly when state=SHIFT.

## Configuration
- ALU_SEQ_DEC_SHIFT_SEQ_EN defined: multi-beat shift sequencing as above.
- Undefined: shamt ignored; every shift emits one SLL1/SRL1 beat with last=1; SHIFT state and rem counter not built; busy tied 0.

## Test plan
- Reset, then aluop=10 op=0001 in_valid=1 out_ready=1 → next cycle out_valid=1 alucontrol=0001 last=1; following cycle out_valid=0.
- aluop=00 op=1100, then aluop=11 op=1110, then aluop=10 op=1010 back-to-back → beats 0000, 1000, 0010 on consecutive cycles, all last=1, in_ready held 1.
- aluop=10 op=0110 shamt=3 (macro on) → three beats 0110, last only on third, busy=1 on first two, in_ready=0 until third; out_ready low for 2 cycles on beat 2 → beat held unchanged.
- op=0111 shamt=0 → single beat 1001 last=1.
- op=0110 shamt=3, reset high after beat 1 taken → out_valid=0 next cycle, no further beats, in_ready=1 after reset released.
- Macro undefined: op=0111 shamt=3 → single beat 0111 last=1, busy stays 0.

Source files
------------

// File: rtl/alu_seq_dec_if.sv
// Request/beat bundle for alu_seq_dec: decode requests in, ALU control beats out.
// slave is the sequencer's view; master is the control-decoder/datapath side.
interface alu_seq_dec_if #(
  parameter int OPW  = 4,
  parameter int CNTW = 2,
  parameter int CTLW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  op;
  logic [1:0]      aluop;
  logic [CNTW-1:0] shamt;
  logic            out_valid;
  logic            out_ready;
  logic [CTLW-1:0] alucontrol;
  logic            last;
  logic            busy;

  modport master (
    output in_valid, op, aluop, shamt, out_ready,
    input  in_ready, out_valid, alucontrol, last, busy
  );

  modport slave (
    input  in_valid, op, aluop, shamt, out_ready,
    output in_ready, out_valid, alucontrol, last, busy
  );
endinterface

// File: rtl/alu_seq_dec.sv
// Sequenced ALU decoder: one request in, a registered stream of ALU control beats out.
// Multi-beat shift sequencing is built only when ALU_SEQ_DEC_SHIFT_SEQ_EN is defined.
module alu_seq_dec #(
  parameter int OPW  = 4,
  parameter int CNTW = 2,
  parameter int CTLW = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_seq_dec_if.slave bus
);

  localparam logic [3:0] CODE_ADD   = 4'b0000;
  localparam logic [3:0] CODE_SUB   = 4'b0001;
  localparam logic [3:0] CODE_PASSB = 4'b1000;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
  localparam logic [3:0] CODE_PASSA = 4'b1001;

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SHIFT = 2'd2} state_e;
  logic [CNTW-1:0] rem_q, rem_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1} state_e;
`endif

  state_e     state_q, state_d;
  logic [3:0] ctl_q, ctl_d;
  logic [3:0] code;
  logic       is_shift;
  logic       accept;
  logic       out_valid_w;
  logic       busy_w;
  logic       unused_inputs;

  // Function codes 000..111 coincide with the ALU codes, so op[2:0] passes straight through.
  always_comb begin
    code     = CODE_ADD;
    is_shift = 1'b0;
    case (bus.aluop)
      2'b00:   code = CODE_ADD;
      2'b01:   code = CODE_SUB;
      2'b11:   code = CODE_PASSB;
      default: begin
        code     = {1'b0, bus.op[2:0]};
        is_shift = (bus.op[2:1] == 2'b11);
      end
    endcase
  end

  assign unused_inputs = ^{bus.op, bus.shamt, is_shift};
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctl_q   <= '0;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
      rem_q   <= rem_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
    rem_d   = rem_q;
`endif
    if (accept) begin
      ctl_d   = code;
      state_d = HOLD;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
      rem_d   = '0;
      if (is_shift) begin
        if (bus.shamt == '0) begin
          ctl_d = CODE_PASSA;
        end else if (bus.shamt != CNTW'(1)) begin
          state_d = SHIFT;
          rem_d   = bus.shamt - CNTW'(1);
        end
      end
`endif
    end else if (bus.out_ready) begin
      case (state_q)
        HOLD: state_d = IDLE;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
        // rem counts beats still to come after the one presented; the last one flips to HOLD.
        SHIFT: begin
          if (rem_q != '0) rem_d = rem_q - CNTW'(1);
          if (rem_q == CNTW'(1)) state_d = HOLD;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    out_valid_w = (state_q != IDLE);
    busy_w      = 1'b0;
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
    busy_w      = (state_q == SHIFT);
`endif
    bus.out_valid       = out_valid_w;
    bus.busy            = busy_w;
    bus.last            = (state_q == HOLD);
    bus.in_ready        = !reset && !busy_w && (!out_valid_w || bus.out_ready);
    bus.alucontrol      = '0;
    bus.alucontrol[3:0] = ctl_q;
  end

endmodule

// File: tb/tb_alu_seq_dec.sv
// Self-checking bench for alu_seq_dec: directed steps then random traffic against a beat-queue model.
// Works with ALU_SEQ_DEC_SHIFT_SEQ_EN defined or undefined.
module tb_alu_seq_dec;
  localparam int OPW  = 4;
  localparam int CNTW = 2;
  localparam int CTLW = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   model_q[$];

  always #5 clk = ~clk;

  alu_seq_dec_if #(.OPW(OPW), .CNTW(CNTW), .CTLW(CTLW)) bus ();

  alu_seq_dec #(.OPW(OPW), .CNTW(CNTW), .CTLW(CTLW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Each queued beat is its ALU code in bits [3:0] with the last flag in bit 4.
  function automatic int decodeCode(input logic [1:0] aluop, input logic [2:0] f);
    if (aluop == 2'b00) return 0;
    if (aluop == 2'b01) return 1;
    if (aluop == 2'b11) return 8;
    return int'(f);
  endfunction

  function automatic void pushRequest(input logic [1:0] aluop, input logic [2:0] f,
                                      input logic [CNTW-1:0] shamt);
    int code;
    int n;
    code = decodeCode(aluop, f);
    n    = int'(shamt);
    if (aluop == 2'b10 && f >= 3'd6) begin
`ifdef ALU_SEQ_DEC_SHIFT_SEQ_EN
      if (n == 0) model_q.push_back(9 + 16);
      else for (int i = 1; i <= n; i++) model_q.push_back(code + ((i == n) ? 16 : 0));
`else
      model_q.push_back(code + 16);
`endif
    end else begin
      model_q.push_back(code + 16);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [3:0] op,
                               input logic [1:0] aluop, input logic [CNTW-1:0] shamt,
                               input bit ordy);
    bit exp_valid;
    bit exp_in_ready;
    bit take;
    bit accept;
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = v;
    bus.op        = op;
    bus.aluop     = aluop;
    bus.shamt     = shamt;
    bus.out_ready = ordy;
    #1;
    exp_valid    = (model_q.size() != 0);
    exp_in_ready = !rst && (model_q.size() <= 1) && (!exp_valid || ordy);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
    checkOutput("busy", 32'(bus.busy), 32'(model_q.size() > 1));
    if (exp_valid) begin
      checkOutput("alucontrol", 32'(bus.alucontrol), 32'(model_q[0] % 16));
      checkOutput("last", 32'(bus.last), 32'(model_q[0] / 16));
    end
    take   = exp_valid && ordy;
    accept = v && exp_in_ready;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (take) void'(model_q.pop_front());
      if (accept) pushRequest(aluop, op[2:0], shamt);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.aluop     = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b0;

    applyStimulus(1, 0, 4'b0000, 2'b00, 2'd0, 0);
    applyStimulus(1, 1, 4'b0001, 2'b10, 2'd0, 1);
    #2;
    checkOutput("reset_alucontrol", 32'(bus.alucontrol), 32'd0);
    checkOutput("reset_last", 32'(bus.last), 32'd0);

    // Single SUB beat, then idle.
    applyStimulus(0, 1, 4'b0001, 2'b10, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);

    // Back-to-back single-beat requests: ADD, PASSB, AND.
    applyStimulus(0, 1, 4'b1100, 2'b00, 2'd0, 1);
    applyStimulus(0, 1, 4'b1110, 2'b11, 2'd0, 1);
    applyStimulus(0, 1, 4'b1010, 2'b10, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);

    // SLL by 3 with a two-cycle stall on the second beat; inputs change mid-sequence.
    applyStimulus(0, 1, 4'b0110, 2'b10, 2'd3, 1);
    applyStimulus(0, 1, 4'b0111, 2'b10, 2'd1, 1);
    applyStimulus(0, 1, 4'b0001, 2'b01, 2'd2, 0);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 0);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);

    // SRL by 0 becomes a single PASSA beat.
    applyStimulus(0, 1, 4'b0111, 2'b10, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);

    // Reset in the middle of a shift sequence.
    applyStimulus(0, 1, 4'b0110, 2'b10, 2'd3, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(1, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);

    // SRL by 3, then a new request offered while the final beat is taken.
    applyStimulus(0, 1, 4'b0111, 2'b10, 2'd3, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 1, 4'b0011, 2'b10, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);
    applyStimulus(0, 0, 4'b0000, 2'b00, 2'd0, 1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    4'($urandom), 2'($urandom), CNTW'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
